edge_level_gen: RTL and testbench

Rebuilds a level waveform from edge-event requests. It is the inverse of the team's edge detector: single-cycle rise/fall request pulses drive a registered level output. Each transition is followed by a programmable minimum dwell time. Requests arriving during the dwell are held in a one-deep, latest-wins pending slot. The block sits on the output side of control paths where software or an FSM issues edge commands and a clean, width-controlled level is required.

---
 rtl/edge_level_gen_pkg.sv | 19 +
 rtl/edge_level_gen_dwell_timer.sv | 29 ++
 rtl/edge_level_gen.sv | 139 +++++++++++++
 tb/tb_edge_level_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/edge_level_gen_pkg.sv
// Shared types for edge_level_gen: request direction and the counter-derived state.
package edge_level_gen_pkg;

  typedef enum logic {
    DIR_FALL = 1'b0,
    DIR_RISE = 1'b1
  } dir_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  // A level value maps onto the direction that would have produced it.
  function automatic dir_t level_to_dir(input logic level);
    return level ? DIR_RISE : DIR_FALL;
  endfunction

endpackage

// File: rtl/edge_level_gen_dwell_timer.sv
// Loadable down-counter that times the dwell after each level transition.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero_o
);

  logic [W-1:0] cnt;

  // Count register: load wins, otherwise decrement toward zero and stop there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= {W{1'b0}};
    end else if (load) begin
      cnt <= value;
    end else if (cnt != {W{1'b0}}) begin
      cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign zero_o = (cnt == {W{1'b0}});

endmodule

// File: rtl/edge_level_gen.sv
// Rebuilds a registered level from rise/fall request pulses, with a programmable
// minimum dwell after each transition and a one-deep latest-wins pending slot.
module edge_level_gen
  import edge_level_gen_pkg::*;
#(
  parameter int   HOLD_W     = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rise_i,
  input  logic              fall_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  output logic              level_o,
  output logic              busy_o,
  output logic              pending_o,
  output logic              rise_done_o,
  output logic              fall_done_o,
  output logic              drop_o
);

  logic              level_r;
  logic              pend_valid_r;
  dir_t              pend_dir_r;
  logic              rise_done_r;
  logic              fall_done_r;
  logic              drop_r;

  logic              zero_s;
  state_t            state_s;
  logic              req_valid_s;
  logic              req_both_s;
  dir_t              req_dir_s;
  logic              take_s;
  logic              eval_s;
  logic              level_nxt_s;
  logic              pend_valid_nxt_s;
  dir_t              pend_dir_nxt_s;
  logic              drop_s;
  logic [HOLD_W-1:0] load_val_s;

  dwell_timer #(.W(HOLD_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (take_s),
    .value   (load_val_s),
    .zero_o  (zero_s)
  );

  assign state_s     = zero_s ? ST_IDLE : ST_DWELL;
  assign req_valid_s = rise_i ^ fall_i;
  assign req_both_s  = rise_i & fall_i;
  assign req_dir_s   = rise_i ? DIR_RISE : DIR_FALL;
  // A hold of 0 behaves as 1, so the counter reload is H-1 with H = max(hold, 1).
  assign load_val_s  = (hold_cycles_i == {HOLD_W{1'b0}}) ? {HOLD_W{1'b0}}
                     : hold_cycles_i - {{(HOLD_W-1){1'b0}}, 1'b1};

  // Request arbitration: pending beats new input in IDLE; otherwise input is judged against the post-edge level.
  always_comb begin
    take_s           = 1'b0;
    eval_s           = 1'b0;
    level_nxt_s      = level_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_dir_nxt_s   = pend_dir_r;
    drop_s           = 1'b0;
    case (state_s)
      ST_IDLE: begin
        if (pend_valid_r) begin
          take_s           = 1'b1;
          level_nxt_s      = (pend_dir_r == DIR_RISE);
          pend_valid_nxt_s = 1'b0;
          eval_s           = 1'b1;
        end else if (req_both_s) begin
          drop_s = 1'b1;
        end else if (req_valid_s) begin
          if (req_dir_s != level_to_dir(level_r)) begin
            take_s      = 1'b1;
            level_nxt_s = (req_dir_s == DIR_RISE);
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          drop_s = 1'b0;
        end
      end
      ST_DWELL: begin
        eval_s = 1'b1;
      end
      default: begin
        eval_s = 1'b0;
      end
    endcase
    if (eval_s) begin
      if (req_both_s) begin
        drop_s = 1'b1;
      end else if (req_valid_s) begin
        if (req_dir_s != level_to_dir(level_nxt_s)) begin
          drop_s           = pend_valid_nxt_s;
          pend_valid_nxt_s = 1'b1;
          pend_dir_nxt_s   = req_dir_s;
        end else begin
          drop_s           = 1'b1;
          pend_valid_nxt_s = 1'b0;
        end
      end else begin
        drop_s = drop_s;
      end
    end else begin
      eval_s = 1'b0;
    end
  end

  // Level, pending slot and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r      <= INIT_LEVEL;
      pend_valid_r <= 1'b0;
      pend_dir_r   <= DIR_FALL;
      rise_done_r  <= 1'b0;
      fall_done_r  <= 1'b0;
      drop_r       <= 1'b0;
    end else begin
      level_r      <= level_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_dir_r   <= pend_dir_nxt_s;
      rise_done_r  <= take_s & level_nxt_s;
      fall_done_r  <= take_s & ~level_nxt_s;
      drop_r       <= drop_s;
    end
  end

  assign level_o     = level_r;
  assign busy_o      = ~zero_s;
  assign pending_o   = pend_valid_r;
  assign rise_done_o = rise_done_r;
  assign fall_done_o = fall_done_r;
  assign drop_o      = drop_r;

endmodule

// File: tb/tb_edge_level_gen.sv
// Table-driven bench for edge_level_gen: expected outputs are queued as each
// vector is driven and popped/compared one edge later.
module tb_edge_level_gen;

  logic       clk;
  logic       reset_n;
  logic       rise;
  logic       fall;
  logic [7:0] hold;
  logic       level, busy, pending, rise_done, fall_done, drop;

  // exp = {level, busy, pending, rise_done, fall_done, drop}
  typedef struct packed {
    logic       rise;
    logic       fall;
    logic [7:0] hold;
    logic [5:0] exp;
  } vec_t;

  localparam int NV = 28;
  vec_t       tbl [NV];
  logic [5:0] exp_q [$];
  int         n_vec;
  int         n_bad;

  edge_level_gen #(.HOLD_W(8), .INIT_LEVEL(1'b0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rise_i        (rise),
    .fall_i        (fall),
    .hold_cycles_i (hold),
    .level_o       (level),
    .busy_o        (busy),
    .pending_o     (pending),
    .rise_done_o   (rise_done),
    .fall_done_o   (fall_done),
    .drop_o        (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_next(input string name, input int idx);
    logic [5:0] e;
    logic [5:0] a;
    a = {level, busy, pending, rise_done, fall_done, drop};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s[%0d]: scoreboard empty, got %b", name, idx, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s[%0d]: got lvl/busy/pend/rd/fd/drop=%b expected %b", name, idx, a, e);
      end
    end
  endtask

  task automatic apply(input string name, input int idx, input vec_t v);
    @(negedge clk);
    rise = v.rise;
    fall = v.fall;
    hold = v.hold;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check_next(name, idx);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    tbl = '{
      // rise with hold 4: busy for 3 cycles
      '{1'b0, 1'b0, 8'd4, 6'b000000},
      '{1'b1, 1'b0, 8'd4, 6'b110100},
      '{1'b0, 1'b0, 8'd4, 6'b110000},
      '{1'b0, 1'b0, 8'd4, 6'b110000},
      '{1'b0, 1'b0, 8'd4, 6'b100000},
      // fall then rise during dwell -> rise pends, executes when idle
      '{1'b0, 1'b1, 8'd4, 6'b010010},
      '{1'b1, 1'b0, 8'd4, 6'b011000},
      '{1'b0, 1'b0, 8'd4, 6'b011000},
      '{1'b0, 1'b0, 8'd4, 6'b001000},
      '{1'b0, 1'b0, 8'd4, 6'b110100},
      // fall then rise during dwell after rise -> cancel with one drop
      '{1'b0, 1'b1, 8'd4, 6'b111000},
      '{1'b1, 1'b0, 8'd4, 6'b110001},
      '{1'b0, 1'b0, 8'd4, 6'b100000},
      '{1'b0, 1'b0, 8'd4, 6'b100000},
      // both high, then redundant rise
      '{1'b1, 1'b1, 8'd4, 6'b100001},
      '{1'b1, 1'b0, 8'd4, 6'b100001},
      '{1'b0, 1'b0, 8'd4, 6'b100000},
      // pending overwritten by a second rise, then executes with hold 3
      '{1'b0, 1'b1, 8'd3, 6'b010010},
      '{1'b1, 1'b0, 8'd3, 6'b011000},
      '{1'b1, 1'b0, 8'd3, 6'b001001},
      '{1'b0, 1'b0, 8'd3, 6'b110100},
      '{1'b0, 1'b0, 8'd3, 6'b110000},
      '{1'b0, 1'b0, 8'd3, 6'b100000},
      // hold 0: toggle every cycle, never busy
      '{1'b0, 1'b1, 8'd0, 6'b000010},
      '{1'b1, 1'b0, 8'd0, 6'b100100},
      '{1'b0, 1'b1, 8'd0, 6'b000010},
      '{1'b1, 1'b0, 8'd0, 6'b100100},
      '{1'b0, 1'b0, 8'd0, 6'b100000}
    };

    reset_n = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    hold    = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(6'b000000);
    check_next("reset", 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply("tbl", i, tbl[i]);
    end

    // Mid-dwell reset with a pending request, then normal latency after release.
    apply("rst_seq", 0, '{1'b0, 1'b1, 8'd4, 6'b010010});
    apply("rst_seq", 1, '{1'b1, 1'b0, 8'd4, 6'b011000});
    @(negedge clk);
    rise = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(6'b000000);
    check_next("async_rst", 0);
    @(negedge clk);
    reset_n = 1'b1;
    apply("rst_seq", 2, '{1'b1, 1'b0, 8'd4, 6'b110100});
    apply("rst_seq", 3, '{1'b0, 1'b0, 8'd4, 6'b110000});

    rise = 1'b0;
    fall = 1'b0;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
